seq_mul: RTL and testbench

Parametrised sequential shift-add multiplier with a start/busy/done handshake. It replaces combinational repeated-addition multiplication with a clocked datapath of bounded latency. It adds a per-operation signed/unsigned mode and an optional early-exit mode. It sits in datapath blocks as a shared low-area multiplier driven by a local controller.

---
 rtl/seq_mul_pkg.sv | 35 +++
 rtl/seq_mul.sv | 94 +++++++++
 tb/tb_seq_mul.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/seq_mul_pkg.sv
// ============================================================================
// seq_mul_pkg : shared state encoding and operand helpers for seq_mul
// Revision    : 1.0
// ============================================================================
`default_nettype none

package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int MAX_W = 64;

    // Counter width able to hold WIDTH-1, never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    // Operand magnitude for a width-bit value held in the low bits of x.
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] x,
                                               input logic signed_mode,
                                               input int width);
        logic [MAX_W-1:0] mask;
        mask = (width >= MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
        if (signed_mode && x[width-1])
            return (~x + 64'd1) & mask;
        return x & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mul.sv
// ============================================================================
// seq_mul : sequential shift-add multiplier, start/busy/done handshake
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t               r_state;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mplier;
    logic [CNT_W-1:0]     r_cnt;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_last;

    assign w_abs_a = WIDTH'(abs_w(64'(a), signed_mode, WIDTH));
    assign w_abs_b = WIDTH'(abs_w(64'(b), signed_mode, WIDTH));

    // Last iteration: fixed count reached, or no multiplier bits left to add.
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) ||
                    (EARLY_EXIT && (r_mplier[WIDTH-1:1] == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_neg    <= 1'b0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                        r_mplier <= w_abs_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (r_mplier[0])
                        r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last)
                        r_state <= FIN;
                end
                FIN: begin
                    product <= r_neg ? (~r_acc + 1'b1) : r_acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_mul.sv
// ============================================================================
// tb_seq_mul : self-checking bench for seq_mul, fixed-latency and early-exit
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_seq_mul;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start0, start1;
    logic           signed_mode;
    logic [W-1:0]   a, b;
    logic           busy0, done0, busy1, done1;
    logic [2*W-1:0] product0, product1;

    int n_checks = 0;
    int n_fail   = 0;
    bit launched = 1'b0;
    logic [2*W-1:0] prev_prod [2];

    always #5 clk = ~clk;

    seq_mul #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_fixed (
        .clk(clk), .rst_n(rst_n), .start(start0), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy0), .done(done0), .product(product0));

    seq_mul #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_early (
        .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy1), .done(done1), .product(product1));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic get_done(input bit ee);
        return ee ? done1 : done0;
    endfunction
    function automatic logic get_busy(input bit ee);
        return ee ? busy1 : busy0;
    endfunction
    function automatic logic [2*W-1:0] get_prod(input bit ee);
        return ee ? product1 : product0;
    endfunction

    task automatic set_start(input bit ee, input logic v);
        if (ee) start1 = v; else start0 = v;
    endtask

    // Reference: plain integer arithmetic on the interpreted operands.
    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] x, input logic [W-1:0] y, input bit sm);
        longint px, py, p;
        px = sm ? longint'($signed(x)) : longint'(x);
        py = sm ? longint'($signed(y)) : longint'(y);
        p  = px * py;
        return p[2*W-1:0];
    endfunction

    function automatic int model_lat(input logic [W-1:0] y, input bit sm, input bit ee);
        int mag, k;
        if (!ee) return W + 1;
        mag = sm ? (($signed(y) < 0) ? -int'($signed(y)) : int'($signed(y))) : int'(y);
        k = 1;
        for (int i = 0; i <= W; i++)
            if ((mag >> i) != 0) k = i + 1;
        return k + 1;
    endfunction

    // Runs one operation; optional ignored start pulses at cycles p1/p2, and
    // an optional back-to-back launch of (na, nb, nsm) in the done cycle.
    task automatic run_op(input bit ee, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit sm, input logic [2*W-1:0] exp_p, input int exp_lat,
                          input int p1, input int p2, input bit chain,
                          input logic [W-1:0] na, input logic [W-1:0] nb, input bit nsm);
        int lat = -1;
        int busy_cnt = 0;
        if (!launched) begin
            @(negedge clk);
            a = x; b = y; signed_mode = sm;
            set_start(ee, 1'b1);
        end
        @(posedge clk); #1;
        launched = 1'b0;
        set_start(ee, 1'b0);
        a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
        if (get_busy(ee)) busy_cnt++;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            set_start(ee, 1'b0);
            if (get_done(ee)) begin
                lat = c;
                break;
            end
            if (get_busy(ee)) busy_cnt++;
            if (c == p1 || c == p2) begin
                a = W'($urandom); b = W'($urandom);
                set_start(ee, 1'b1);
            end
            if (c == 2) check("product_held", 64'(get_prod(ee)), 64'(prev_prod[ee]));
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("product", 64'(get_prod(ee)), 64'(exp_p));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_lat));
        check("busy_low_in_done", 64'(get_busy(ee)), 64'd0);
        prev_prod[ee] = exp_p;
        if (chain) begin
            a = na; b = nb; signed_mode = nsm;
            set_start(ee, 1'b1);
            launched = 1'b1;
        end else begin
            @(posedge clk); #1;
            check("done_one_cycle", 64'(get_done(ee)), 64'd0);
        end
    endtask

    task automatic run_rand(input bit ee);
        logic [W-1:0] x, y;
        bit sm;
        x = W'($urandom); y = W'($urandom); sm = 1'($urandom);
        if ($urandom_range(0, 3) == 0) y = W'(1) << $urandom_range(0, W - 1);
        run_op(ee, x, y, sm, model_prod(x, y, sm), model_lat(y, sm, ee), 0, 0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        signed_mode = 1'b0; a = '0; b = '0;
        prev_prod[0] = '0; prev_prod[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_product", 64'(product0), 64'd0);
        check("rst_product_ee", 64'(product1), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // Fixed latency directed cases
        run_op(0, 8'd13, 8'd11, 0, 16'h008F, 9, 0, 0, 0, '0, '0, 0);
        run_op(0, 8'd255, 8'd255, 0, 16'hFE01, 9, 0, 0, 0, '0, '0, 0);
        run_op(0, 8'h80, 8'h80, 1, 16'h4000, 9, 0, 0, 0, '0, '0, 0);
        run_op(0, 8'hFD, 8'd5, 1, 16'hFFF1, 9, 0, 0, 0, '0, '0, 0);

        // Ignored starts while busy, then back-to-back start in the done cycle
        run_op(0, 8'd13, 8'd11, 0, 16'h008F, 9, 3, 5, 1, 8'd2, 8'd3, 0);
        run_op(0, 8'd2, 8'd3, 0, 16'h0006, 9, 0, 0, 0, '0, '0, 0);

        // Early-exit directed cases
        run_op(1, 8'd200, 8'd1, 0, 16'd200, 2, 0, 0, 0, '0, '0, 0);
        run_op(1, 8'd200, 8'd0, 0, 16'd0, 2, 0, 0, 0, '0, '0, 0);
        run_op(1, 8'd200, 8'h80, 0, 16'd25600, 9, 0, 0, 0, '0, '0, 0);

        for (int i = 0; i < 25; i++) begin
            run_rand(0);
            run_rand(1);
        end

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        a = 8'd9; b = 8'd9; signed_mode = 1'b0; start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy0), 64'd0);
        check("arst_done", 64'(done0), 64'd0);
        check("arst_product", 64'(product0), 64'd0);
        check("arst_product_ee", 64'(product1), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        prev_prod[0] = '0; prev_prod[1] = '0;
        begin
            int stray = 0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #1;
                if (done0 || busy0) stray++;
            end
            check("no_stray_done", 64'(stray), 64'd0);
        end
        run_op(0, 8'd7, 8'd6, 0, 16'd42, 9, 0, 0, 0, '0, '0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
